et_err_ctrl: RTL and testbench
==============================

// Module: et_err_ctrl
// PURPOSE
//  Sequencer for N_CH et_err capture channels. On start it clears the channels and arms them,
//  then waits for every channel's TLK/DC 232-bit error buses or a timeout. It then streams all
//  buses as 32-bit words over a valid/ready link to the readout FIFO.
// PARAMETERS
//  N_CH        4     number of et_err channels controlled (1..16)
//  LENGTH_ERR  232   error-bus payload bits per bus (must match et_err)
//  WORD_W      32    output word width
//  TIMEOUT     4096  COLLECT cycles allowed before giving up (>=2)
// PORTS
//  clk           in   1             system clock
//  rst_n         in   1             asynchronous active-low reset
//  start         in   1             1-cycle request to run a collection (ignored unless IDLE)
//  bypass_cfg    in   1             force channels to report without waiting for headers
//  ch_live       out  N_CH          per-channel in_live drive (0 clears et_err)
//  ch_bypass     out  1             common bypass drive to all channels
//  got_tlk       in   N_CH          per-channel got_tlk_err_bus
//  got_dc        in   N_CH          per-channel got_dc_err_bus
//  tlk_bus       in   N_CH*232      channel c at [c*232 +: 232]
//  dc_bus        in   N_CH*232      channel c at [c*232 +: 232]
//  out_data      out  WORD_W        readout word
//  out_valid     out  1             out_data valid
//  out_ready     in   1             downstream accepts word
//  out_last      out  1             final word of the record
//  busy          out  1             high in every state except IDLE
//  done          out  1             1-cycle pulse when record complete
//  timeout_mask  out  N_CH          channel c missing TLK or DC at end of COLLECT
// BEHAVIOUR
//  Reset (async): state=IDLE; ch_live=0, ch_bypass=0, out_valid=0, out_last=0, out_data=0.
//  Reset also forces busy=0, done=0, timeout_mask=0, timer=0, ch/word counters=0.
//  IDLE: start=1 -> CLEAR; latch bypass_cfg; clear timeout_mask.
//  CLEAR: exactly 1 cycle with ch_live=0 -> COLLECT. timer=0.
//  COLLECT: ch_live=all 1s; ch_bypass=latched bypass_cfg.
//  COLLECT, timer increments each cycle.
//  COLLECT exits to READOUT when &(got_tlk & got_dc)=1 or timer==TIMEOUT-1, whichever first.
//  If both hold in the same cycle, all channels complete wins: timeout_mask=0.
//  On exit, timeout_mask[c] = ~(got_tlk[c] & got_dc[c]), sampled in the exit cycle.
//  READOUT: ch_live stays all 1s so et_err holds its buses. Channels are emitted in order 0..N_CH-1.
//  Each channel emits W=1+2*ceil(LENGTH_ERR/WORD_W) words (17 at defaults). Word order:
//   w0 header {8'hEE, 8'(c), 14'b0, got_dc[c], got_tlk[c]}.
//   w1..w8 TLK bus, bits [k*32 +: 32], k=0..7. w9..w16 DC bus, same slicing.
//   Bits beyond LENGTH_ERR are 0: the last slice carries bits 231:224 in [7:0], with [31:8]=0.
//   A bus whose got flag is 0 is emitted as all-zero words (header still sent).
//  Handshake: a word transfers when out_valid & out_ready.
//  out_data, out_valid and out_last hold stable until the transfer; no bubbles are required.
//  A new word is presented the cycle after a transfer.
//  out_last=1 only on word 16 of channel N_CH-1. Total record = N_CH*17 words (68 at defaults).
//  After the out_last transfer -> DONE.
//  DONE: 1 cycle; done=1, ch_live=0, ch_bypass=0, out_valid=0 -> IDLE.
//  start outside IDLE has no effect. out_ready stalls of any length are allowed with no data loss.
//  timeout_mask holds its value until the next start.
//  Got flags are sampled only in COLLECT and at word emission; deasserting later is not an error.
//  rst_n low mid-record aborts immediately to the reset values; the partial record is not resumed.
// TESTING
//  1 All N_CH channels raise got_tlk/got_dc 300 cycles after CLEAR; out_ready=1 -> 68 words,
//    header c=2 = 32'hEE020003, out_last on word 68, done pulse, timeout_mask=0.
//  2 Channel 1 never raises got_dc, TIMEOUT=4096 -> READOUT starts at timer 4095; timeout_mask=4'b0010.
//    Channel 1 header = 32'hEE010001; its DC words are all 0.
//  3 tlk_bus ch0 = all 1s -> words w1..w7 = 32'hFFFFFFFF, w8 = 32'h000000FF.
//  4 out_ready toggled randomly (~30% duty) -> identical 68-word sequence as scenario 1.
//    out_data stays stable whenever out_valid=1 and out_ready=0.
//  5 start pulsed during COLLECT and READOUT -> ignored; exactly one record output.
//    start with bypass_cfg=1 -> ch_bypass=1 throughout COLLECT.
//  6 rst_n driven low at word 30 -> ch_live=0, out_valid=0 immediately.
//    A new start then yields a full 68-word record from channel 0.

Source files
------------

// File: rtl/et_err_ctrl_if.sv
// Readout stream link between et_err_ctrl and the readout FIFO.
// A word transfers on any cycle where out_valid and out_ready are both high.
interface et_err_ctrl_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/et_err_ctrl.sv
// et_err_ctrl: clears and arms N_CH et_err channels, waits for their TLK/DC error buses
// (or a timeout), then streams every bus as WORD_W-bit words over the readout link.
module et_err_ctrl #(
  parameter int N_CH       = 4,
  parameter int LENGTH_ERR = 232,
  parameter int WORD_W     = 32,
  parameter int TIMEOUT    = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       bypass_cfg,
  output logic [N_CH-1:0]            ch_live,
  output logic                       ch_bypass,
  input  logic [N_CH-1:0]            got_tlk,
  input  logic [N_CH-1:0]            got_dc,
  input  logic [N_CH*LENGTH_ERR-1:0] tlk_bus,
  input  logic [N_CH*LENGTH_ERR-1:0] dc_bus,
  et_err_ctrl_if.master              rd,
  output logic                       busy,
  output logic                       done,
  output logic [N_CH-1:0]            timeout_mask
);
  localparam int NSL   = (LENGTH_ERR + WORD_W - 1) / WORD_W;
  localparam int NWORD = 1 + 2 * NSL;
  localparam int PAD_W = NSL * WORD_W;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WD_W  = $clog2(NWORD);
  localparam int SL_W  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int TM_W  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COLLECT, S_READOUT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [TM_W-1:0]       timer;
  logic [CH_W-1:0]       ch_cnt, sel_ch;
  logic [WD_W-1:0]       wd_cnt, sel_w;
  logic                  byp_q;
  logic                  all_got, tmo_hit, xfer, sel_last;
  logic                  g_t, g_d;
  logic [LENGTH_ERR-1:0] tlk_ch [N_CH];
  logic [LENGTH_ERR-1:0] dc_ch  [N_CH];
  logic [PAD_W-1:0]      tlk_pad, dc_pad;
  logic [WORD_W-1:0]     tlk_sl [NSL];
  logic [WORD_W-1:0]     dc_sl  [NSL];
  logic [SL_W-1:0]       sl_idx_t, sl_idx_d;
  logic [WORD_W-1:0]     word_nxt;

  function automatic logic [WORD_W-1:0] gate_word(input logic [WORD_W-1:0] w, input logic got);
    return got ? w : '0;
  endfunction

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign tlk_ch[c] = tlk_bus[c*LENGTH_ERR +: LENGTH_ERR];
    assign dc_ch[c]  = dc_bus[c*LENGTH_ERR +: LENGTH_ERR];
  end

  // Zero-extend to a whole number of words so the tail slice carries 0s above LENGTH_ERR.
  assign tlk_pad = PAD_W'(tlk_ch[sel_ch]);
  assign dc_pad  = PAD_W'(dc_ch[sel_ch]);

  for (genvar k = 0; k < NSL; k++) begin : g_sl
    assign tlk_sl[k] = tlk_pad[k*WORD_W +: WORD_W];
    assign dc_sl[k]  = dc_pad[k*WORD_W +: WORD_W];
  end

  assign all_got = &(got_tlk & got_dc);
  assign tmo_hit = (timer == TM_W'(TIMEOUT - 1));
  assign xfer    = rd.out_valid & rd.out_ready;

  // Index of the word to present next: channel 0 header on COLLECT exit, else successor.
  always_comb begin
    sel_ch = ch_cnt;
    sel_w  = wd_cnt + 1'b1;
    if (state == S_COLLECT) begin
      sel_ch = '0;
      sel_w  = '0;
    end else if (wd_cnt == WD_W'(NWORD - 1)) begin
      sel_ch = ch_cnt + 1'b1;
      sel_w  = '0;
    end
  end

  assign g_t      = got_tlk[sel_ch];
  assign g_d      = got_dc[sel_ch];
  assign sel_last = (sel_ch == CH_W'(N_CH - 1)) && (sel_w == WD_W'(NWORD - 1));

  always_comb begin
    sl_idx_t = SL_W'(sel_w - 1'b1);
    sl_idx_d = SL_W'(sel_w - WD_W'(NSL + 1));
    if (sel_w == '0)
      word_nxt = WORD_W'({8'hEE, 8'(sel_ch), 14'b0, g_d, g_t});
    else if (sel_w <= WD_W'(NSL))
      word_nxt = gate_word(tlk_sl[sl_idx_t], g_t);
    else
      word_nxt = gate_word(dc_sl[sl_idx_d], g_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ch_live   = '0;
    ch_bypass = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: state_nxt = S_COLLECT;
      S_COLLECT: begin
        ch_live   = '1;
        ch_bypass = byp_q;
        if (all_got || tmo_hit) state_nxt = S_READOUT;
      end
      S_READOUT: begin
        // Channels stay live so et_err keeps its captured buses while they are read.
        ch_live   = '1;
        ch_bypass = byp_q;
        if (xfer && rd.out_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer        <= '0;
      ch_cnt       <= '0;
      wd_cnt       <= '0;
      byp_q        <= 1'b0;
      timeout_mask <= '0;
      rd.out_data  <= '0;
      rd.out_valid <= 1'b0;
      rd.out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            byp_q        <= bypass_cfg;
            timeout_mask <= '0;
          end
        end
        S_CLEAR: timer <= '0;
        S_COLLECT: begin
          timer <= timer + 1'b1;
          if (all_got || tmo_hit) begin
            timeout_mask <= ~(got_tlk & got_dc);
            ch_cnt       <= '0;
            wd_cnt       <= '0;
            rd.out_data  <= word_nxt;
            rd.out_valid <= 1'b1;
            rd.out_last  <= 1'b0;
          end
        end
        S_READOUT: begin
          if (xfer) begin
            if (rd.out_last) begin
              rd.out_valid <= 1'b0;
              rd.out_last  <= 1'b0;
            end else begin
              ch_cnt      <= sel_ch;
              wd_cnt      <= sel_w;
              rd.out_data <= word_nxt;
              rd.out_last <= sel_last;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_et_err_ctrl.sv
// Directed bench for et_err_ctrl: full records, timeout, random back-pressure,
// ignored starts, bypass drive and mid-record reset.
module tb_et_err_ctrl;
  localparam int N_CH = 4;
  localparam int LEN  = 232;
  localparam int WW   = 32;
  localparam int NW   = 17;
  localparam int REC  = N_CH * NW;

  logic                  clk = 1'b0;
  logic                  rst_n, start, bypass_cfg;
  logic [N_CH-1:0]       ch_live, got_tlk, got_dc, timeout_mask;
  logic                  ch_bypass, busy, done;
  logic [N_CH*LEN-1:0]   tlk_bus, dc_bus;
  logic [LEN-1:0]        tlk_arr [N_CH];
  logic [LEN-1:0]        dc_arr  [N_CH];

  et_err_ctrl_if #(.WORD_W(WW)) rd_if ();

  et_err_ctrl #(.N_CH(N_CH), .LENGTH_ERR(LEN), .WORD_W(WW), .TIMEOUT(4096)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bypass_cfg(bypass_cfg),
    .ch_live(ch_live), .ch_bypass(ch_bypass), .got_tlk(got_tlk), .got_dc(got_dc),
    .tlk_bus(tlk_bus), .dc_bus(dc_bus), .rd(rd_if), .busy(busy), .done(done),
    .timeout_mask(timeout_mask)
  );

  for (genvar c = 0; c < N_CH; c++) begin : g_bus
    assign tlk_bus[c*LEN +: LEN] = tlk_arr[c];
    assign dc_bus[c*LEN +: LEN]  = dc_arr[c];
  end

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  int          done_cnt   = 0;
  int          rdy_mode   = 1;
  logic [32:0] rec_q [$];
  bit          stall_prev = 1'b0;
  logic [32:0] stall_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Downstream ready: low, high, or ~30% random duty, updated just after each edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rd_if.out_ready = 1'b0;
      1:       rd_if.out_ready = 1'b1;
      default: rd_if.out_ready = ($urandom_range(0, 99) < 30);
    endcase
  end

  // Inputs only move just after posedge, so the negedge view is what the next edge sees.
  always @(negedge clk) begin
    if (rd_if.out_valid && rd_if.out_ready) rec_q.push_back({rd_if.out_last, rd_if.out_data});
    if (done) done_cnt++;
    if (stall_prev && rd_if.out_valid) chk("stall_hold", {rd_if.out_last, rd_if.out_data}, stall_word);
    stall_prev = rd_if.out_valid && !rd_if.out_ready;
    stall_word = {rd_if.out_last, rd_if.out_data};
  end

  function automatic logic [31:0] exp_word(input int c, input int w, input logic gt, input logic gd);
    logic [31:0]  r;
    logic [LEN-1:0] src;
    int           base;
    if (w == 0) return {8'hEE, c[7:0], 14'b0, gd, gt};
    src  = (w <= 8) ? tlk_arr[c] : dc_arr[c];
    base = ((w <= 8) ? (w - 1) : (w - 9)) * 32;
    r    = '0;
    for (int b = 0; b < 32; b++)
      if (base + b < LEN) r[b] = src[base + b];
    if (!((w <= 8) ? gt : gd)) r = '0;
    return r;
  endfunction

  function automatic logic [31:0] qd(input int i);
    if (i < rec_q.size()) return rec_q[i][31:0];
    return 'x;
  endfunction

  task automatic check_record(input string tag, input logic [N_CH-1:0] gt, input logic [N_CH-1:0] gd);
    chk({tag, "_count"}, rec_q.size(), REC);
    for (int i = 0; i < REC && i < rec_q.size(); i++) begin
      chk($sformatf("%s_w%0d", tag, i), rec_q[i][31:0], exp_word(i / NW, i % NW, gt[i / NW], gd[i / NW]));
      chk($sformatf("%s_last%0d", tag, i), rec_q[i][32], (i == REC - 1));
    end
  endtask

  task automatic run_record(input string tag, input int got_at, input logic [N_CH-1:0] gt,
                            input logic [N_CH-1:0] gd, input logic byp, input bit poke,
                            output int first_v);
    int k;
    int d0;
    rec_q.delete();
    d0      = done_cnt;
    first_v = -1;
    got_tlk = '0;
    got_dc  = '0;
    bypass_cfg = byp;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
    bypass_cfg = 1'b0;
    chk({tag, "_clear_live"}, ch_live, '0);
    chk({tag, "_clear_busy"}, busy, 1'b1);
    k = 0;
    while (done_cnt == d0 && k < 6000) begin
      if (k == got_at) begin
        got_tlk = gt;
        got_dc  = gd;
      end
      start = poke && ((k == 100) || (first_v >= 0 && k == first_v + 10));
      tick(1);
      k++;
      if (first_v < 0 && rd_if.out_valid) first_v = k;
      if (k == 50 || k == 250) begin
        chk({tag, "_coll_live"}, ch_live, {N_CH{1'b1}});
        chk({tag, "_coll_byp"}, ch_bypass, byp);
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, done_cnt != d0, 1'b1);
    tick(5);
    chk({tag, "_one_done"}, done_cnt - d0, 1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_live"}, ch_live, '0);
    chk({tag, "_idle_byp"}, ch_bypass, 1'b0);
  endtask

  initial begin
    int fv;
    int n;
    rst_n = 1'b0; start = 1'b0; bypass_cfg = 1'b0; got_tlk = '0; got_dc = '0;
    rd_if.out_ready = 1'b1;
    for (int c = 0; c < N_CH; c++)
      for (int b = 0; b < LEN; b++) begin
        tlk_arr[c][b] = (c == 0) ? 1'b1 : (((b * 7 + c * 3) % 5) < 2);
        dc_arr[c][b]  = (((b * 3 + c * 11) % 7) < 3);
      end
    tick(3);
    chk("rst_live", ch_live, '0);
    chk("rst_byp", ch_bypass, 1'b0);
    chk("rst_valid", rd_if.out_valid, 1'b0);
    chk("rst_last", rd_if.out_last, 1'b0);
    chk("rst_data", rd_if.out_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tmask", timeout_mask, '0);
    rst_n = 1'b1;
    tick(2);

    // All channels complete, ready always high
    rdy_mode = 1;
    run_record("s1", 300, '1, '1, 1'b0, 1'b0, fv);
    check_record("s1", '1, '1);
    chk("s1_hdr_c2", qd(2 * NW), 32'hEE020003);
    for (int w = 1; w <= 7; w++) chk($sformatf("s1_tlk0_w%0d", w), qd(w), 32'hFFFFFFFF);
    chk("s1_tlk0_w8", qd(8), 32'h000000FF);
    chk("s1_tmask", timeout_mask, 4'b0000);

    // Channel 1 never delivers DC: timeout path
    run_record("s2", 300, 4'b1111, 4'b1101, 1'b0, 1'b0, fv);
    chk("s2_first_valid_cyc", fv, 4097);
    chk("s2_tmask", timeout_mask, 4'b0010);
    chk("s2_hdr_c1", qd(NW), 32'hEE010001);
    for (int w = 9; w <= 16; w++) chk($sformatf("s2_dc1_w%0d", w), qd(NW + w), 32'h0);
    check_record("s2", 4'b1111, 4'b1101);

    // Random back-pressure
    rdy_mode = 2;
    run_record("s4", 300, '1, '1, 1'b0, 1'b0, fv);
    check_record("s4", '1, '1);
    rdy_mode = 1;

    // Stray starts during COLLECT/READOUT, bypass requested
    run_record("s5", 300, '1, '1, 1'b1, 1'b1, fv);
    check_record("s5", '1, '1);
    chk("s5_tmask", timeout_mask, 4'b0000);

    // Reset in the middle of readout, then a fresh record
    rec_q.delete();
    got_tlk = '1; got_dc = '1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (rec_q.size() < 30 && n < 1000) begin
      tick(1);
      n++;
    end
    chk("s6_reach30", rec_q.size() >= 30, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_live", ch_live, '0);
    chk("s6_rst_valid", rd_if.out_valid, 1'b0);
    chk("s6_rst_data", rd_if.out_data, 32'h0);
    chk("s6_rst_busy", busy, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    run_record("s6", 20, '1, '1, 1'b0, 1'b0, fv);
    check_record("s6", '1, '1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
